// File: rtl/fighter_pkg.sv
// Shared definitions for the fighter action arbiter: command codes,
// controller state-vector bit positions and the per-player FSM states.
package fighter_pkg;

   // Command codes presented to the game engine (0 is never issued)
   localparam logic [2:0] CMD_LEFT   = 3'd1;
   localparam logic [2:0] CMD_RIGHT  = 3'd2;
   localparam logic [2:0] CMD_UP     = 3'd3;
   localparam logic [2:0] CMD_DOWN   = 3'd4;
   localparam logic [2:0] CMD_ATTACK = 3'd5;
   localparam logic [2:0] CMD_PARRY  = 3'd6;

   // Bit positions inside a 7-bit controller state vector (bit 0 unused)
   localparam int BIT_LEFT   = 1;
   localparam int BIT_RIGHT  = 2;
   localparam int BIT_UP     = 3;
   localparam int BIT_DOWN   = 4;
   localparam int BIT_ATTACK = 5;
   localparam int BIT_PARRY  = 6;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACTIVE   = 2'd1,
      ST_COOLDOWN = 2'd2
   } pstate_e;

   // Attack and parry start an active window; movement does not
   function automatic logic is_action(input logic [2:0] code);
      return (code == CMD_ATTACK) || (code == CMD_PARRY);
   endfunction

endpackage

// File: rtl/fighter_action_arbiter_player.sv
// Per-player action sequencer: edge detect on attack/parry, one-deep
// action latch, one-deep pending slot and the IDLE/ACTIVE/COOLDOWN FSM.
module player_action_fsm
   import fighter_pkg::*;
#(
   parameter int ATK_FRAMES   = 30,
   parameter int PARRY_FRAMES = 20,
   parameter int COOL_FRAMES  = 15
) (
   input  logic       clk,
   input  logic       reset_l,
   input  logic [6:0] state_i,
   input  logic       tick_i,
   input  logic       grant_i,
   output logic       slot_valid_o,
   output logic [2:0] slot_code_o,
   output logic       busy_o
);

   localparam logic [15:0] ATK_CNT   = 16'(ATK_FRAMES);
   localparam logic [15:0] PARRY_CNT = 16'(PARRY_FRAMES);
   localparam logic [15:0] COOL_CNT  = 16'(COOL_FRAMES);

   pstate_e     fsm_q;
   logic [15:0] cnt_q;
   logic        busy_q;

   logic [1:0]  state_q, state_d;       // registered copy of parry/attack bits
   logic        latch_vld_q, latch_vld_d;
   logic [2:0]  latch_code_q, latch_code_d;
   logic        slot_vld_q, slot_vld_d;
   logic [2:0]  slot_code_q, slot_code_d;

   logic [1:0]  edge_w;                 // [1] parry rose, [0] attack rose
   logic        act_grant_w;
   logic        stay_idle_w;
   logic        dir_vld_w;
   logic [2:0]  dir_code_w;
   logic        unused_bit0;

   assign unused_bit0 = state_i[0];
   assign edge_w      = state_i[BIT_PARRY:BIT_ATTACK] & ~state_q;
   assign act_grant_w = grant_i && is_action(slot_code_q);
   // IDLE and not leaving it on this edge: the only window where new work is taken
   assign stay_idle_w = (fsm_q == ST_IDLE) && !act_grant_w;

   // Held direction with fixed precedence LEFT > RIGHT > UP > DOWN
   always_comb begin
      dir_vld_w  = 1'b1;
      dir_code_w = CMD_LEFT;
      if (state_i[BIT_LEFT])       dir_code_w = CMD_LEFT;
      else if (state_i[BIT_RIGHT]) dir_code_w = CMD_RIGHT;
      else if (state_i[BIT_UP])    dir_code_w = CMD_UP;
      else if (state_i[BIT_DOWN])  dir_code_w = CMD_DOWN;
      else                         dir_vld_w  = 1'b0;
   end

   // Next state of edge history, action latch and pending slot
   always_comb begin
      state_d      = state_i[BIT_PARRY:BIT_ATTACK];
      latch_vld_d  = latch_vld_q;
      latch_code_d = latch_code_q;
      slot_vld_d   = slot_vld_q;
      slot_code_d  = slot_code_q;
      if (grant_i) slot_vld_d = 1'b0;
      if (stay_idle_w && !slot_vld_q) begin
         if (latch_vld_q) begin
            slot_vld_d  = 1'b1;
            slot_code_d = latch_code_q;
            latch_vld_d = 1'b0;
         end else if (tick_i && dir_vld_w) begin
            slot_vld_d  = 1'b1;
            slot_code_d = dir_code_w;
         end
      end
      // A fresh edge overwrites whatever the latch holds; parry wins a tie
      if (stay_idle_w && (edge_w != 2'b00)) begin
         latch_vld_d  = 1'b1;
         latch_code_d = edge_w[1] ? CMD_PARRY : CMD_ATTACK;
      end
   end

   // Register edge history, latch and slot
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q      <= '0;
         latch_vld_q  <= 1'b0;
         latch_code_q <= '0;
         slot_vld_q   <= 1'b0;
         slot_code_q  <= '0;
      end else begin
         state_q      <= state_d;
         latch_vld_q  <= latch_vld_d;
         latch_code_q <= latch_code_d;
         slot_vld_q   <= slot_vld_d;
         slot_code_q  <= slot_code_d;
      end
   end

   // Player FSM with frame counter; busy registered alongside the state
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         fsm_q  <= ST_IDLE;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         case (fsm_q)
            ST_IDLE: begin
               if (act_grant_w) begin
                  fsm_q  <= ST_ACTIVE;
                  busy_q <= 1'b1;
                  cnt_q  <= (slot_code_q == CMD_PARRY) ? PARRY_CNT : ATK_CNT;
               end
            end
            ST_ACTIVE: begin
               if (cnt_q == 16'd1) begin
                  fsm_q <= ST_COOLDOWN;
                  cnt_q <= COOL_CNT;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            ST_COOLDOWN: begin
               if (cnt_q == 16'd1) begin
                  fsm_q  <= ST_IDLE;
                  busy_q <= 1'b0;
                  cnt_q  <= '0;
               end else begin
                  cnt_q <= cnt_q - 16'd1;
               end
            end
            default: begin
               fsm_q  <= ST_IDLE;
               busy_q <= 1'b0;
               cnt_q  <= '0;
            end
         endcase
      end
   end

   assign slot_valid_o = slot_vld_q;
   assign slot_code_o  = slot_code_q;
   assign busy_o       = busy_q;

endmodule

// File: rtl/fighter_action_arbiter.sv
// Two-player controller to game-engine command arbiter. Holds the movement
// tick divider, the shared-port arbiter and the output register.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking;
// without it player 1 always wins a tie.
module fighter_action_arbiter
   import fighter_pkg::*;
#(
   parameter int MOVE_DIV     = 1666667,
   parameter int ATK_FRAMES   = 30,
   parameter int PARRY_FRAMES = 20,
   parameter int COOL_FRAMES  = 15
) (
   input  logic       clk,
   input  logic       reset_l,
   input  logic [6:0] p1_state,
   input  logic [6:0] p2_state,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic       cmd_player,
   output logic [2:0] cmd_code,
   output logic       p1_busy,
   output logic       p2_busy
);

   localparam logic [23:0] TICK_LAST = 24'(MOVE_DIV - 1);

   logic [23:0] tick_cnt_q, tick_cnt_d;
   logic        tick_w;

   logic        s1_vld, s2_vld;
   logic [2:0]  s1_code, s2_code;
   logic        load_w, pick2_w, grant1_w, grant2_w;

   logic        cmd_valid_q;
   logic        cmd_player_q;
   logic [2:0]  cmd_code_q;

   assign tick_w     = (tick_cnt_q == TICK_LAST);
   assign tick_cnt_d = tick_w ? '0 : tick_cnt_q + 24'd1;

   // Free-running movement sample divider
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) tick_cnt_q <= '0;
      else          tick_cnt_q <= tick_cnt_d;
   end

   player_action_fsm #(
      .ATK_FRAMES  (ATK_FRAMES),
      .PARRY_FRAMES(PARRY_FRAMES),
      .COOL_FRAMES (COOL_FRAMES)
   ) u_p1 (
      .clk         (clk),
      .reset_l     (reset_l),
      .state_i     (p1_state),
      .tick_i      (tick_w),
      .grant_i     (grant1_w),
      .slot_valid_o(s1_vld),
      .slot_code_o (s1_code),
      .busy_o      (p1_busy)
   );

   player_action_fsm #(
      .ATK_FRAMES  (ATK_FRAMES),
      .PARRY_FRAMES(PARRY_FRAMES),
      .COOL_FRAMES (COOL_FRAMES)
   ) u_p2 (
      .clk         (clk),
      .reset_l     (reset_l),
      .state_i     (p2_state),
      .tick_i      (tick_w),
      .grant_i     (grant2_w),
      .slot_valid_o(s2_vld),
      .slot_code_o (s2_code),
      .busy_o      (p2_busy)
   );

   // Output register may take a new command when empty or being consumed
   assign load_w = !cmd_valid_q || cmd_ready;

`ifdef ARB_ROUND_ROBIN_EN
   logic rr_q;       // player favoured on the next tie (0 = player 1)

   assign pick2_w = s2_vld && (!s1_vld || rr_q);

   // Pointer only moves when both players actually contend
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l)                        rr_q <= 1'b0;
      else if (load_w && s1_vld && s2_vld) rr_q <= !pick2_w;
   end
`else
   assign pick2_w = s2_vld && !s1_vld;
`endif

   assign grant1_w = load_w && s1_vld && !pick2_w;
   assign grant2_w = load_w && pick2_w;

   // Command output register; payload holds while the engine stalls
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         cmd_valid_q  <= 1'b0;
         cmd_player_q <= 1'b0;
         cmd_code_q   <= '0;
      end else if (load_w) begin
         cmd_valid_q <= s1_vld || s2_vld;
         if (s1_vld || s2_vld) begin
            cmd_player_q <= pick2_w;
            cmd_code_q   <= pick2_w ? s2_code : s1_code;
         end
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_player = cmd_player_q;
   assign cmd_code   = cmd_code_q;

endmodule

// File: tb/tb_fighter_action_arbiter.sv
// Directed testbench for fighter_action_arbiter with small frame counts.
module tb_fighter_action_arbiter;

   logic       clk = 1'b0;
   logic       reset_l = 1'b0;
   logic [6:0] p1_state = '0;
   logic [6:0] p2_state = '0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic       cmd_player;
   logic [2:0] cmd_code;
   logic       p1_busy;
   logic       p2_busy;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] K_LEFT = 7'b0000010;
   localparam logic [6:0] K_ATK  = 7'b0100000;
   localparam logic [6:0] K_BOTH = 7'b1100000;

   always #5 clk = ~clk;

   fighter_action_arbiter #(
      .MOVE_DIV    (8),
      .ATK_FRAMES  (4),
      .PARRY_FRAMES(3),
      .COOL_FRAMES (2)
   ) dut (
      .clk       (clk),
      .reset_l   (reset_l),
      .p1_state  (p1_state),
      .p2_state  (p2_state),
      .cmd_ready (cmd_ready),
      .cmd_valid (cmd_valid),
      .cmd_player(cmd_player),
      .cmd_code  (cmd_code),
      .p1_busy   (p1_busy),
      .p2_busy   (p2_busy)
   );

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reset with all inputs idle; the next rising edge after return is e1
   task automatic do_reset();
      reset_l   = 1'b0;
      p1_state  = '0;
      p2_state  = '0;
      cmd_ready = 1'b0;
      cyc(2);
      reset_l = 1'b1;
   endtask

   task automatic test_reset();
      reset_l = 1'b0;
      #1;
      checks++;
      if ({cmd_valid, cmd_player, cmd_code, p1_busy, p2_busy} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b expected 0000000", {cmd_valid, cmd_player, cmd_code, p1_busy, p2_busy});
      end
      do_reset();
      cyc(3);
      checks++;
      if ({cmd_valid, p1_busy, p2_busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_idle got %b expected 000", {cmd_valid, p1_busy, p2_busy});
      end
   endtask

   task automatic test_single_attack();
      int busy_n;
      do_reset();
      cmd_ready = 1'b1;
      cyc(2);
      p1_state = K_ATK;                   // sampled at k = e3
      cyc(2);                             // after k+1
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early_valid got %b expected 0", cmd_valid);
      end
      cyc(1);                             // after k+2
      checks++;
      if ({cmd_valid, cmd_player, cmd_code, p1_busy} !== {1'b1, 1'b0, 3'd5, 1'b1}) begin
         errors++;
         $display("FAIL single_cmd got v%b p%b c%0d b%b expected v1 p0 c5 b1", cmd_valid, cmd_player, cmd_code, p1_busy);
      end
      busy_n = 1;
      for (int i = 3; i <= 14; i++) begin
         cyc(1);
         busy_n += int'(p1_busy);
         checks++;
         if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_no_repeat cycle k+%0d got valid %b expected 0", i, cmd_valid);
         end
         if (i == 3) p1_state = '0;
         if (i == 4) p1_state = K_ATK;    // press while busy is dropped
      end
      checks++;
      if (busy_n != 6) begin
         errors++;
         $display("FAIL single_busy_len got %0d expected 6", busy_n);
      end
      p1_state = '0;
   endtask

   task automatic test_simultaneous();
      logic exp_first;
      do_reset();
      cmd_ready = 1'b1;
      cyc(1);
      p1_state = K_ATK;
      p2_state = K_ATK;                   // k = e2
      cyc(3);                             // after k+2
      checks++;
      if ({cmd_valid, cmd_player, cmd_code} !== {1'b1, 1'b0, 3'd5}) begin
         errors++;
         $display("FAIL simul_first got v%b p%b c%0d expected v1 p0 c5", cmd_valid, cmd_player, cmd_code);
      end
      cyc(1);
      checks++;
      if ({cmd_valid, cmd_player, cmd_code, p1_busy, p2_busy} !== {1'b1, 1'b1, 3'd5, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL simul_second got v%b p%b c%0d b%b%b expected v1 p1 c5 b11", cmd_valid, cmd_player, cmd_code, p1_busy, p2_busy);
      end
      cyc(1);
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL simul_drain got %b expected 0", cmd_valid);
      end
      p1_state = '0;
      p2_state = '0;
      cyc(6);                             // after k+10, both idle
      checks++;
      if ({p1_busy, p2_busy} !== 2'b00) begin
         errors++;
         $display("FAIL simul_idle got %b expected 00", {p1_busy, p2_busy});
      end
      p1_state = K_ATK;
      p2_state = K_ATK;
`ifdef ARB_ROUND_ROBIN_EN
      exp_first = 1'b1;
`else
      exp_first = 1'b0;
`endif
      cyc(3);
      checks++;
      if ({cmd_valid, cmd_player} !== {1'b1, exp_first}) begin
         errors++;
         $display("FAIL simul_pair2_first got v%b p%b expected v1 p%b", cmd_valid, cmd_player, exp_first);
      end
      cyc(1);
      checks++;
      if ({cmd_valid, cmd_player} !== {1'b1, !exp_first}) begin
         errors++;
         $display("FAIL simul_pair2_second got v%b p%b expected v1 p%b", cmd_valid, cmd_player, !exp_first);
      end
      p1_state = '0;
      p2_state = '0;
      cyc(8);
   endtask

   task automatic test_backpressure();
      do_reset();
      p1_state = K_LEFT;                  // ticks at e8, e16, ...
      cyc(8);
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_pre_tick got %b expected 0", cmd_valid);
      end
      cyc(1);                             // after e9
      checks++;
      if ({cmd_valid, cmd_player, cmd_code} !== {1'b1, 1'b0, 3'd1}) begin
         errors++;
         $display("FAIL bp_first got v%b p%b c%0d expected v1 p0 c1", cmd_valid, cmd_player, cmd_code);
      end
      for (int i = 10; i <= 13; i++) begin
         cyc(1);
         checks++;
         if ({cmd_valid, cmd_code} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL bp_hold e%0d got v%b c%0d expected v1 c1", i, cmd_valid, cmd_code);
         end
      end
      cmd_ready = 1'b1;                   // accepted at e14
      for (int i = 14; i <= 16; i++) begin
         cyc(1);
         checks++;
         if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_single e%0d got valid %b expected 0", i, cmd_valid);
         end
      end
      cyc(1);                             // after e17
      checks++;
      if ({cmd_valid, cmd_code} !== {1'b1, 3'd1}) begin
         errors++;
         $display("FAIL bp_next_tick got v%b c%0d expected v1 c1", cmd_valid, cmd_code);
      end
      p1_state = '0;
      cyc(2);
   endtask

   task automatic test_attack_parry();
      int busy_n;
      do_reset();
      cmd_ready = 1'b1;
      cyc(1);
      p2_state = K_BOTH;                  // k = e2
      cyc(3);
      checks++;
      if ({cmd_valid, cmd_player, cmd_code, p2_busy} !== {1'b1, 1'b1, 3'd6, 1'b1}) begin
         errors++;
         $display("FAIL ap_cmd got v%b p%b c%0d b%b expected v1 p1 c6 b1", cmd_valid, cmd_player, cmd_code, p2_busy);
      end
      busy_n = 1;
      for (int i = 3; i <= 8; i++) begin
         cyc(1);
         busy_n += int'(p2_busy);
      end
      checks++;
      if (busy_n != 5) begin
         errors++;
         $display("FAIL ap_busy_len got %0d expected 5", busy_n);
      end
      p2_state = '0;
      cyc(2);
   endtask

   task automatic test_preempt();
      do_reset();
      p1_state = K_LEFT;
      cyc(9);                             // after e9
      checks++;
      if ({cmd_valid, cmd_code} !== {1'b1, 3'd1}) begin
         errors++;
         $display("FAIL pre_left got v%b c%0d expected v1 c1", cmd_valid, cmd_code);
      end
      p1_state = K_LEFT | K_ATK;          // edge at e10
      cyc(3);                             // after e12
      checks++;
      if ({cmd_valid, cmd_code, p1_busy} !== {1'b1, 3'd1, 1'b0}) begin
         errors++;
         $display("FAIL pre_stall got v%b c%0d b%b expected v1 c1 b0", cmd_valid, cmd_code, p1_busy);
      end
      cmd_ready = 1'b1;
      cyc(1);                             // after e13
      checks++;
      if ({cmd_valid, cmd_code, p1_busy} !== {1'b1, 3'd5, 1'b1}) begin
         errors++;
         $display("FAIL pre_attack got v%b c%0d b%b expected v1 c5 b1", cmd_valid, cmd_code, p1_busy);
      end
      for (int i = 14; i <= 24; i++) begin
         cyc(1);
         checks++;
         if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL pre_no_move e%0d got valid %b expected 0", i, cmd_valid);
         end
         if (i == 19) begin
            checks++;
            if (p1_busy !== 1'b0) begin
               errors++;
               $display("FAIL pre_busy_end got %b expected 0", p1_busy);
            end
         end
      end
      cyc(1);                             // after e25
      checks++;
      if ({cmd_valid, cmd_player, cmd_code} !== {1'b1, 1'b0, 3'd1}) begin
         errors++;
         $display("FAIL pre_move_resume got v%b p%b c%0d expected v1 p0 c1", cmd_valid, cmd_player, cmd_code);
      end
      p1_state = '0;
      cyc(2);
   endtask

   task automatic test_reset_mid();
      do_reset();
      cmd_ready = 1'b1;
      cyc(1);
      p1_state = K_ATK;                   // k = e2
      cyc(3);
      checks++;
      if ({cmd_valid, cmd_code, p1_busy} !== {1'b1, 3'd5, 1'b1}) begin
         errors++;
         $display("FAIL rmid_cmd got v%b c%0d b%b expected v1 c5 b1", cmd_valid, cmd_code, p1_busy);
      end
      cyc(1);                             // mid-ACTIVE
      reset_l = 1'b0;
      #1;
      checks++;
      if ({cmd_valid, cmd_player, cmd_code, p1_busy, p2_busy} !== 7'b0) begin
         errors++;
         $display("FAIL rmid_async got %b expected 0000000", {cmd_valid, cmd_player, cmd_code, p1_busy, p2_busy});
      end
      p1_state = '0;
      cyc(2);
      reset_l = 1'b1;
      cyc(1);
      p1_state = K_ATK;                   // k = e2 after release
      cyc(2);
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL rmid_early got %b expected 0", cmd_valid);
      end
      cyc(1);
      checks++;
      if ({cmd_valid, cmd_player, cmd_code, p1_busy} !== {1'b1, 1'b0, 3'd5, 1'b1}) begin
         errors++;
         $display("FAIL rmid_after got v%b p%b c%0d b%b expected v1 p0 c5 b1", cmd_valid, cmd_player, cmd_code, p1_busy);
      end
      p1_state = '0;
      cyc(8);
   endtask

   initial begin
      test_reset();
      test_single_attack();
      test_simultaneous();
      test_backpressure();
      test_attack_parry();
      test_preempt();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fighter_action_arbiter.md
# fighter_action_arbiter

Sits between the two breadboard controllers and the game engine. Each player's 7-bit controller state vector is turned into discrete action commands: movement (rate-limited), attack and parry. Attack and parry are sequenced through per-player active/cooldown windows. Both players share one valid/ready command port into the game engine, and this block arbitrates that port between them.

## Interface
- `MOVE_DIV`, default 1666667: cycles between movement samples (≥1); the tick counter is 24 bits.
- `ATK_FRAMES`, default 30: active cycles after an attack is granted (1..65535).
- `PARRY_FRAMES`, default 20: active cycles after a parry is granted (1..65535).
- `COOL_FRAMES`, default 15: cooldown cycles after any active window (1..65535).
- `clk` in 1: single clock.
- `reset_l` in 1: asynchronous, active-low reset.
- `p1_state` in 7: player 1 state vector. Bit 1 left, 2 right, 3 up, 4 down, 5 attack, 6 parry; bit 0 is ignored.
- `p2_state` in 7: player 2 state vector, same encoding.
- `cmd_ready` in 1: the engine accepts the command this cycle.
- `cmd_valid` out 1: a command is presented.
- `cmd_player` out 1: 0 = player 1, 1 = player 2.
- `cmd_code` out 3: 1 LEFT, 2 RIGHT, 3 UP, 4 DOWN, 5 ATTACK, 6 PARRY; 0 is never issued.
- `p1_busy` out 1: player 1 FSM is not in IDLE.
- `p2_busy` out 1: player 2 FSM is not in IDLE.

## Operation
- **Edge detection:** each player keeps a registered copy `state_q`. Action edge = `state & ~state_q` on bits 5 and 6.
- **Action latch (one deep, per player):**
  - Loaded on an action edge only while the FSM is IDLE.
  - If attack and parry rise in the same cycle, PARRY is latched.
  - A later edge overwrites an unconsumed latch.
  - Edges outside IDLE are dropped.
- **Pending slot (one deep, per player).** Loaded only when empty and the FSM is IDLE:
  - The action latch has priority; loading the slot clears the latch.
  - Otherwise, on the tick (`MOVE_DIV` counter wrap), the first held direction in order LEFT > RIGHT > UP > DOWN is loaded.
  - No direction held means nothing is loaded.
- **Player FSM:**
  - IDLE: on grant of ATTACK or PARRY, go to ACTIVE. The counter loads `ATK_FRAMES` or `PARRY_FRAMES`. Movement grants keep the FSM in IDLE.
  - ACTIVE: the counter decrements each cycle. When it reaches 1, go to COOLDOWN with the counter at `COOL_FRAMES`.
  - COOLDOWN: the counter decrements. When it reaches 1, go to IDLE.
- **Arbiter and output register:**
  - When `cmd_valid` is 0, or is 1 with `cmd_ready` 1, the output register loads from a player with a non-empty slot. That slot is cleared on the same edge.
  - If both slots are non-empty, the grant goes to the player not granted last (round-robin pointer, reset to player 1).
  - Nothing pending means `cmd_valid` goes to 0.
- **Handshake:** `cmd_player` and `cmd_code` hold stable while `cmd_valid && !cmd_ready`. A grant counts as accepted when it leaves the slot for the output register. The FSM enters ACTIVE on that same edge.
- **Reset** (asynchronous, at any time, including mid-ACTIVE):
  - `cmd_valid`, `cmd_player`, `cmd_code`, `p1_busy`, `p2_busy` go to 0.
  - Slots and latches clear, FSMs return to IDLE, counters and `state_q` clear, and the pointer returns to player 1.

## Timing
- **Action latency:** an action edge sampled at clock edge k loads the latch at k. The slot loads at k+1. `cmd_valid` rises after edge k+2 if the output is free.
- **Movement latency:** a tick at edge k loads the slot at k. `cmd_valid` rises after edge k+1.
- **Sustained throughput:** one command per cycle.
- **busy timing:** `busy` is high from the acceptance edge for exactly ACTIVE + COOL frames (e.g. 45 cycles for an attack at defaults).
- **Movement during busy:** movement is suppressed while busy; the tick is missed, not queued.

## Configuration
- `ARB_ROUND_ROBIN_EN`
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, player 1 always wins a tie and the pointer is removed.

## Structure
- Package `fighter_pkg` holds:
  - command code constants
  - state-vector bit indices (LEFT=1 … PARRY=6)
  - player FSM state typedef (IDLE/ACTIVE/COOLDOWN)
- Sub-module `player_action_fsm`, instantiated twice. It contains the edge detect, action latch, pending slot, FSM and counter. It exports `slot_valid`, `slot_code` and `busy`, and takes `grant` as input.
- The top level holds the tick counter, the arbiter and the output register.

## Test plan
Scenarios run with `MOVE_DIV=8`, `ATK_FRAMES=4`, `PARRY_FRAMES=3`, `COOL_FRAMES=2`.
- **Single attack:** P1 bit5 rises, `cmd_ready`=1 → `cmd_valid`=1, player 0, code 5, two cycles after the sampling edge. `p1_busy` is high for 6 cycles. A second press inside that window produces no command.
- **Simultaneous presses:** P1 and P2 both press attack on the same edge → P1 is granted first and P2 the next cycle. With `ARB_ROUND_ROBIN_EN` defined, a second identical pair is granted P2 first.
- **Backpressure:** `cmd_ready`=0 for 5 cycles with P1 LEFT held → code 1 stays stable and only one command is issued. The next move comes at the following tick after acceptance.
- **Attack+parry rise together:** P2 bits 5 and 6 rise together → code 6, and `p2_busy` is high for 5 cycles.
- **Action preempts movement:** P1 LEFT is pending with `cmd_ready`=0 when attack rises → LEFT is issued first, then ATTACK. No LEFT is issued during busy.
- **Reset mid-action:** assert `reset_l`=0 mid-ACTIVE → all outputs 0 immediately. After release, a new press is accepted normally.
